// File: rtl/global_buffer_mp.sv
`default_nettype none
// ============================================================================
// Module   : global_buffer_mp
// Brief    : Single-clock dual-port global buffer: narrow strobed lane port A,
//            wide lane-masked word port B, write-first reads, collision count.
// Revision : 1.0 - initial release
// ============================================================================
module global_buffer_mp #(
    parameter int WORD_WIDTH   = 128,
    parameter int LANE_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1,
    localparam int LANES = WORD_WIDTH / LANE_WIDTH,
    localparam int LSEL  = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    a_en_i,
    input  logic                    a_we_i,
    input  logic [AW+LSEL-1:0]      a_addr_i,
    input  logic [LANE_WIDTH/8-1:0] a_wstrb_i,
    input  logic [LANE_WIDTH-1:0]   a_wdata_i,
    output logic [LANE_WIDTH-1:0]   a_rdata_o,
    output logic                    a_rvalid_o,
    input  logic                    b_en_i,
    input  logic                    b_we_i,
    input  logic [AW-1:0]           b_addr_i,
    input  logic [LANES-1:0]        b_lane_mask_i,
    input  logic [WORD_WIDTH-1:0]   b_wdata_i,
    output logic [WORD_WIDTH-1:0]   b_rdata_o,
    output logic                    b_rvalid_o,
    output logic                    collision_o,
    output logic [15:0]             collision_cnt_o
);
    localparam int LANE_BYTES = LANE_WIDTH / 8;
    localparam int WORD_BYTES = WORD_WIDTH / 8;

    if (LANE_WIDTH <= 0 || (LANE_WIDTH % 8) != 0 || (WORD_WIDTH % LANE_WIDTH) != 0) begin : g_bad_width
        $error("global_buffer_mp: WORD_WIDTH must be a multiple of LANE_WIDTH, LANE_WIDTH a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("global_buffer_mp: READ_LATENCY must be 1 or 2");
    end

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    logic [AW-1:0]   w_a_word;
    logic [LSEL-1:0] w_a_lane;
    logic            w_a_in;
    logic            w_b_in;
    logic            w_a_wr;
    logic            w_b_wr;
    logic            w_same;
    logic            w_collision;

    assign w_a_word    = a_addr_i[AW+LSEL-1:LSEL];
    assign w_a_lane    = a_addr_i[LSEL-1:0];
    assign w_a_in      = (32'(w_a_word) < DEPTH) && (32'(w_a_lane) < LANES);
    assign w_b_in      = 32'(b_addr_i) < DEPTH;
    assign w_a_wr      = a_en_i && a_we_i && w_a_in;
    assign w_b_wr      = b_en_i && b_we_i && w_b_in;
    assign w_same      = a_en_i && b_en_i && w_a_in && w_b_in && (w_a_word == b_addr_i);
    assign w_collision = w_same && (a_we_i || b_we_i);

    logic [WORD_WIDTH-1:0] w_a_old;
    logic [WORD_WIDTH-1:0] w_b_old;
    logic [WORD_WIDTH-1:0] w_a_new;
    logic [WORD_WIDTH-1:0] w_b_new;
    logic [WORD_WIDTH-1:0] w_a_rep;
    logic [WORD_BYTES-1:0] w_a_bmask;
    logic [WORD_BYTES-1:0] w_b_bmask;
    logic [LANE_WIDTH-1:0] w_a_lanes [LANES];
    logic [LANE_WIDTH-1:0] w_a_rd;
    logic [WORD_WIDTH-1:0] w_b_rd;

    assign w_a_old = w_a_in ? r_mem[w_a_word] : '0;
    assign w_b_old = w_b_in ? r_mem[b_addr_i] : '0;
    assign w_a_rep = {LANES{a_wdata_i}};

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        for (genvar gb = 0; gb < LANE_BYTES; gb++) begin : g_byte
            assign w_a_bmask[gl*LANE_BYTES+gb] = (w_a_lane == LSEL'(gl)) && a_wstrb_i[gb];
            assign w_b_bmask[gl*LANE_BYTES+gb] = b_lane_mask_i[gl];
        end
        assign w_a_lanes[gl] = w_a_new[gl*LANE_WIDTH +: LANE_WIDTH];
    end

    // Both ports compute the same merged word on a same-word access, so each
    // port's read sees the other's write; B's masked lanes take priority.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_merge
        assign w_a_new[8*gi +: 8] = (w_same && w_b_wr && w_b_bmask[gi]) ? b_wdata_i[8*gi +: 8] :
                                    (w_a_wr && w_a_bmask[gi])           ? w_a_rep[8*gi +: 8]   :
                                                                          w_a_old[8*gi +: 8];
        assign w_b_new[8*gi +: 8] = (w_b_wr && w_b_bmask[gi])           ? b_wdata_i[8*gi +: 8] :
                                    (w_same && w_a_wr && w_a_bmask[gi]) ? w_a_rep[8*gi +: 8]   :
                                                                          w_b_old[8*gi +: 8];
    end

    assign w_a_rd = w_a_in ? w_a_lanes[w_a_lane] : '0;
    assign w_b_rd = w_b_in ? w_b_new : '0;

    always_ff @(posedge clk_i) begin
        if (w_a_wr) begin
            r_mem[w_a_word] <= w_a_new;
        end
        if (w_b_wr) begin
            r_mem[b_addr_i] <= w_b_new;
        end
    end

    logic                  r_a_valid_s1;
    logic [LANE_WIDTH-1:0] r_a_rdata_s1;
    logic                  r_b_valid_s1;
    logic [WORD_WIDTH-1:0] r_b_rdata_s1;
    logic                  r_collision;
    logic [15:0]           r_collision_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a_valid_s1    <= 1'b0;
            r_a_rdata_s1    <= '0;
            r_b_valid_s1    <= 1'b0;
            r_b_rdata_s1    <= '0;
            r_collision     <= 1'b0;
            r_collision_cnt <= 16'd0;
        end else begin
            r_a_valid_s1 <= a_en_i;
            r_b_valid_s1 <= b_en_i;
            if (a_en_i) begin
                r_a_rdata_s1 <= w_a_rd;
            end
            if (b_en_i) begin
                r_b_rdata_s1 <= w_b_rd;
            end
            r_collision <= w_collision;
            if (w_collision && (r_collision_cnt != 16'hFFFF)) begin
                r_collision_cnt <= r_collision_cnt + 16'd1;
            end
        end
    end

    assign collision_o     = r_collision;
    assign collision_cnt_o = r_collision_cnt;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_a_valid_s2;
        logic [LANE_WIDTH-1:0] r_a_rdata_s2;
        logic                  r_b_valid_s2;
        logic [WORD_WIDTH-1:0] r_b_rdata_s2;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_a_valid_s2 <= 1'b0;
                r_a_rdata_s2 <= '0;
                r_b_valid_s2 <= 1'b0;
                r_b_rdata_s2 <= '0;
            end else begin
                r_a_valid_s2 <= r_a_valid_s1;
                r_b_valid_s2 <= r_b_valid_s1;
                if (r_a_valid_s1) begin
                    r_a_rdata_s2 <= r_a_rdata_s1;
                end
                if (r_b_valid_s1) begin
                    r_b_rdata_s2 <= r_b_rdata_s1;
                end
            end
        end

        assign a_rvalid_o = r_a_valid_s2;
        assign a_rdata_o  = r_a_rdata_s2;
        assign b_rvalid_o = r_b_valid_s2;
        assign b_rdata_o  = r_b_rdata_s2;
    end else begin : g_lat1
        assign a_rvalid_o = r_a_valid_s1;
        assign a_rdata_o  = r_a_rdata_s1;
        assign b_rvalid_o = r_b_valid_s1;
        assign b_rdata_o  = r_b_rdata_s1;
    end

endmodule
`default_nettype wire

// File: tb/tb_global_buffer_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_global_buffer_mp
// Brief    : Self-checking bench; latency-1 and latency-2 instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_global_buffer_mp;
    localparam int WW    = 128;
    localparam int LW    = 32;
    localparam int DEPTH = 200;
    localparam int AW    = 8;
    localparam int LSEL  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            a_en = 1'b0;
    logic            a_we = 1'b0;
    logic [AW+LSEL-1:0] a_addr = '0;
    logic [3:0]      a_wstrb = '0;
    logic [LW-1:0]   a_wdata = '0;
    logic            b_en = 1'b0;
    logic            b_we = 1'b0;
    logic [AW-1:0]   b_addr = '0;
    logic [3:0]      b_mask = '0;
    logic [WW-1:0]   b_wdata = '0;

    logic [LW-1:0] a_rdata1, a_rdata2;
    logic          a_rvalid1, a_rvalid2;
    logic [WW-1:0] b_rdata1, b_rdata2;
    logic          b_rvalid1, b_rvalid2;
    logic          coll1, coll2;
    logic [15:0]   cnt1, cnt2;

    global_buffer_mp #(.WORD_WIDTH(WW), .LANE_WIDTH(LW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_wstrb_i(a_wstrb), .a_wdata_i(a_wdata),
        .a_rdata_o(a_rdata1), .a_rvalid_o(a_rvalid1),
        .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_lane_mask_i(b_mask), .b_wdata_i(b_wdata),
        .b_rdata_o(b_rdata1), .b_rvalid_o(b_rvalid1),
        .collision_o(coll1), .collision_cnt_o(cnt1)
    );

    global_buffer_mp #(.WORD_WIDTH(WW), .LANE_WIDTH(LW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_wstrb_i(a_wstrb), .a_wdata_i(a_wdata),
        .a_rdata_o(a_rdata2), .a_rvalid_o(a_rvalid2),
        .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_lane_mask_i(b_mask), .b_wdata_i(b_wdata),
        .b_rdata_o(b_rdata2), .b_rvalid_o(b_rvalid2),
        .collision_o(coll2), .collision_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    // Reference: buffer contents plus the expected output state of each instance.
    logic [WW-1:0] m_mem [DEPTH];
    logic          e1_av, e1_bv, e2_av, e2_bv, p_av, p_bv, e_coll;
    logic [LW-1:0] e1_ad, e2_ad, p_ad;
    logic [WW-1:0] e1_bd, e2_bd, p_bd;
    logic [15:0]   e_cnt;
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic model_clear();
        e1_av = 0; e1_bv = 0; e2_av = 0; e2_bv = 0; p_av = 0; p_bv = 0; e_coll = 0;
        e1_ad = '0; e2_ad = '0; p_ad = '0; e1_bd = '0; e2_bd = '0; p_bd = '0; e_cnt = '0;
    endtask

    // One clock: the reference applies A's write, then B's (so B wins on
    // shared lanes), and both reads observe the resulting contents.
    task automatic cycle();
        int            aw, al, bw;
        logic          ai, bi, c;
        logic [LW-1:0] ra;
        logic [WW-1:0] rb;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            aw = int'(a_addr[AW+LSEL-1:LSEL]);
            al = int'(a_addr[LSEL-1:0]);
            bw = int'(b_addr);
            ai = aw < DEPTH;
            bi = bw < DEPTH;
            if (a_en && a_we && ai)
                for (int j = 0; j < 4; j++)
                    if (a_wstrb[j]) m_mem[aw][al*32 + 8*j +: 8] = a_wdata[8*j +: 8];
            if (b_en && b_we && bi)
                for (int l = 0; l < 4; l++)
                    if (b_mask[l]) m_mem[bw][32*l +: 32] = b_wdata[32*l +: 32];
            ra = ai ? m_mem[aw][al*32 +: 32] : '0;
            rb = bi ? m_mem[bw] : '0;
            c  = a_en && b_en && ai && bi && (aw == bw) && (a_we || b_we);
            e2_av = p_av; if (p_av) e2_ad = p_ad;
            e2_bv = p_bv; if (p_bv) e2_bd = p_bd;
            p_av = a_en; p_ad = ra;
            p_bv = b_en; p_bd = rb;
            e1_av = a_en; if (a_en) e1_ad = ra;
            e1_bv = b_en; if (b_en) e1_bd = rb;
            e_coll = c;
            if (c && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic drive_a(input logic en, input logic we, input int word, input int lane,
                           input logic [3:0] strb, input logic [LW-1:0] d);
        a_en = en; a_we = we; a_addr = {AW'(word), LSEL'(lane)}; a_wstrb = strb; a_wdata = d;
    endtask

    task automatic drive_b(input logic en, input logic we, input int word,
                           input logic [3:0] mask, input logic [WW-1:0] d);
        b_en = en; b_we = we; b_addr = AW'(word); b_mask = mask; b_wdata = d;
    endtask

    task automatic idle();
        drive_a(0, 0, 0, 0, 4'h0, '0);
        drive_b(0, 0, 0, 4'h0, '0);
    endtask

    function automatic logic [WW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_clear();
        repeat (3) cycle();
        n_cmp++;
        if ({a_rvalid1, a_rdata1, b_rvalid1, b_rdata1, coll1, cnt1} !== '0) begin
            n_fail++;
            $display("FAIL reset_lat1: got av=%0b ad=%h bv=%0b bd=%h col=%0b cnt=%h, want all 0",
                     a_rvalid1, a_rdata1, b_rvalid1, b_rdata1, coll1, cnt1);
        end
        n_cmp++;
        if ({a_rvalid2, a_rdata2, b_rvalid2, b_rdata2, coll2, cnt2} !== '0) begin
            n_fail++;
            $display("FAIL reset_lat2: got av=%0b ad=%h bv=%0b bd=%h col=%0b cnt=%h, want all 0",
                     a_rvalid2, a_rdata2, b_rvalid2, b_rdata2, coll2, cnt2);
        end
        rst = 1'b0;
        for (int w = 0; w < DEPTH; w++) begin
            drive_b(1, 1, w, 4'hF, rand_word());
            cycle();
        end
        idle();
        cycle();
        n_cmp++;
        if (b_rdata2 !== e2_bd) begin
            n_fail++;
            $display("FAIL fill_last_word: got %h, want %h", b_rdata2, e2_bd);
        end
    endtask

    task automatic test_reset_read();
        drive_b(1, 1, 5, 4'hF, 128'h00000004_00000003_00000002_00000001);
        cycle();
        drive_b(0, 0, 0, 4'h0, '0);
        drive_a(1, 0, 5, 2, 4'h0, '0);
        cycle();
        n_cmp++;
        if (a_rvalid1 !== 1'b1 || a_rdata1 !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL read_lane_lat1: got v=%0b d=%h, want v=1 d=00000003", a_rvalid1, a_rdata1);
        end
        n_cmp++;
        if (a_rvalid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_lane_lat2_early: got v=%0b, want v=0", a_rvalid2);
        end
        idle();
        cycle();
        n_cmp++;
        if (a_rvalid2 !== 1'b1 || a_rdata2 !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL read_lane_lat2: got v=%0b d=%h, want v=1 d=00000003", a_rvalid2, a_rdata2);
        end
        n_cmp++;
        if (a_rvalid1 !== 1'b0 || a_rdata1 !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL rdata_hold: got v=%0b d=%h, want v=0 d=00000003", a_rvalid1, a_rdata1);
        end
    endtask

    task automatic test_byte_strobe();
        drive_b(1, 1, 7, 4'b0010, {32'h0, 32'h0, 32'h11223344, 32'h0});
        cycle();
        drive_b(0, 0, 0, 4'h0, '0);
        drive_a(1, 1, 7, 1, 4'b0101, 32'hAABBCCDD);
        cycle();
        n_cmp++;
        if (a_rvalid1 !== 1'b1 || a_rdata1 !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strobe_write_rdata: got v=%0b d=%h, want v=1 d=11bb33dd", a_rvalid1, a_rdata1);
        end
        drive_a(0, 0, 0, 0, 4'h0, '0);
        drive_b(1, 0, 7, 4'h0, '0);
        cycle();
        idle();
        cycle();
        n_cmp++;
        if (b_rdata1[63:32] !== 32'h11BB33DD || b_rdata2[63:32] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strobe_lane1: got lat1=%h lat2=%h, want 11bb33dd", b_rdata1[63:32], b_rdata2[63:32]);
        end
    endtask

    task automatic test_write_collision();
        logic [15:0] c0;
        c0 = e_cnt;
        drive_a(1, 1, 9, 0, 4'hF, 32'hFFFF_FFFF);
        drive_b(1, 1, 9, 4'b0001, '0);
        cycle();
        n_cmp++;
        if (coll1 !== 1'b1 || coll2 !== 1'b1 || cnt1 !== c0 + 16'd1 || cnt2 !== c0 + 16'd1) begin
            n_fail++;
            $display("FAIL wr_collision_pulse: got col=%0b/%0b cnt=%h/%h, want col=1 cnt=%h",
                     coll1, coll2, cnt1, cnt2, c0 + 16'd1);
        end
        n_cmp++;
        if (a_rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_collision_a_sees_b: got %h, want 00000000", a_rdata1);
        end
        idle();
        cycle();
        n_cmp++;
        if (coll1 !== 1'b0 || cnt1 !== c0 + 16'd1) begin
            n_fail++;
            $display("FAIL wr_collision_single: got col=%0b cnt=%h, want col=0 cnt=%h", coll1, cnt1, c0 + 16'd1);
        end
        drive_b(1, 0, 9, 4'h0, '0);
        cycle();
        idle();
        cycle();
        n_cmp++;
        if (b_rdata1[31:0] !== 32'h0 || b_rdata2[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_collision_b_wins: got lat1=%h lat2=%h, want 00000000", b_rdata1[31:0], b_rdata2[31:0]);
        end
    endtask

    task automatic test_merge_forward();
        logic [15:0] c0;
        c0 = e_cnt;
        drive_a(1, 1, 9, 3, 4'hF, 32'h12345678);
        drive_b(1, 0, 9, 4'h0, '0);
        cycle();
        n_cmp++;
        if (b_rdata1[127:96] !== 32'h12345678 || b_rdata1 !== e1_bd) begin
            n_fail++;
            $display("FAIL forward_b_read: got %h, want %h (lane3 12345678)", b_rdata1, e1_bd);
        end
        n_cmp++;
        if (coll1 !== 1'b1 || cnt1 !== c0 + 16'd1) begin
            n_fail++;
            $display("FAIL forward_count: got col=%0b cnt=%h, want col=1 cnt=%h", coll1, cnt1, c0 + 16'd1);
        end
        idle();
        cycle();
        n_cmp++;
        if (b_rvalid2 !== 1'b1 || b_rdata2[127:96] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL forward_b_read_lat2: got v=%0b d=%h, want v=1 d=12345678", b_rvalid2, b_rdata2[127:96]);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] c0;
        c0 = e_cnt;
        drive_a(1, 1, 200, 0, 4'hF, 32'hDEADBEEF);
        drive_b(1, 0, 200, 4'h0, '0);
        cycle();
        n_cmp++;
        if (b_rvalid1 !== 1'b1 || b_rdata1 !== '0 || a_rvalid1 !== 1'b1 || a_rdata1 !== '0) begin
            n_fail++;
            $display("FAIL oor_read: got bv=%0b bd=%h av=%0b ad=%h, want bv=1 bd=0 av=1 ad=0",
                     b_rvalid1, b_rdata1, a_rvalid1, a_rdata1);
        end
        n_cmp++;
        if (coll1 !== 1'b0 || cnt1 !== c0) begin
            n_fail++;
            $display("FAIL oor_no_collision: got col=%0b cnt=%h, want col=0 cnt=%h", coll1, cnt1, c0);
        end
        idle();
        cycle();
        n_cmp++;
        if (b_rvalid2 !== 1'b1 || b_rdata2 !== '0) begin
            n_fail++;
            $display("FAIL oor_read_lat2: got v=%0b d=%h, want v=1 d=0", b_rvalid2, b_rdata2);
        end
    endtask

    task automatic test_random();
        int aw, bw;
        for (int i = 0; i < 3000; i++) begin
            aw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
            bw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
            drive_a($urandom_range(0, 3) != 0, 1'($urandom), aw, int'($urandom_range(0, 3)),
                    4'($urandom), $urandom);
            drive_b($urandom_range(0, 3) != 0, 1'($urandom), bw, 4'($urandom), rand_word());
            cycle();
            n_cmp++;
            if ({a_rvalid1, a_rdata1, b_rvalid1, b_rdata1} !== {e1_av, e1_ad, e1_bv, e1_bd}) begin
                n_fail++;
                $display("FAIL rand_lat1 #%0d: got av=%0b ad=%h bv=%0b bd=%h, want av=%0b ad=%h bv=%0b bd=%h",
                         i, a_rvalid1, a_rdata1, b_rvalid1, b_rdata1, e1_av, e1_ad, e1_bv, e1_bd);
            end
            n_cmp++;
            if ({a_rvalid2, a_rdata2, b_rvalid2, b_rdata2} !== {e2_av, e2_ad, e2_bv, e2_bd}) begin
                n_fail++;
                $display("FAIL rand_lat2 #%0d: got av=%0b ad=%h bv=%0b bd=%h, want av=%0b ad=%h bv=%0b bd=%h",
                         i, a_rvalid2, a_rdata2, b_rvalid2, b_rdata2, e2_av, e2_ad, e2_bv, e2_bd);
            end
            n_cmp++;
            if ({coll1, cnt1, coll2, cnt2} !== {e_coll, e_cnt, e_coll, e_cnt}) begin
                n_fail++;
                $display("FAIL rand_collision #%0d: got col=%0b/%0b cnt=%h/%h, want col=%0b cnt=%h",
                         i, coll1, coll2, cnt1, cnt2, e_coll, e_cnt);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 70000; i++) begin
            drive_a(1, 1, i % 8, int'($urandom_range(0, 3)), 4'($urandom), $urandom);
            drive_b(1, 1, i % 8, 4'($urandom), rand_word());
            cycle();
        end
        n_cmp++;
        if (cnt1 !== 16'hFFFF || cnt2 !== 16'hFFFF || e_cnt !== 16'hFFFF || coll1 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation: got cnt=%h/%h col=%0b model=%h, want cnt=ffff col=1", cnt1, cnt2, coll1, e_cnt);
        end
        idle();
        cycle();
        n_cmp++;
        if (cnt1 !== 16'hFFFF || coll1 !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation_hold: got cnt=%h col=%0b, want cnt=ffff col=0", cnt1, coll1);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [WW-1:0] w9;
        w9 = m_mem[9];
        drive_b(1, 0, 9, 4'h0, '0);
        cycle();
        idle();
        rst = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if ({b_rvalid2, b_rdata2, a_rvalid2, a_rdata2, cnt2} !== '0 ||
            {b_rvalid1, b_rdata1, cnt1, coll1} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got bv2=%0b bd2=%h cnt2=%h bv1=%0b bd1=%h cnt1=%h, want all 0",
                     b_rvalid2, b_rdata2, cnt2, b_rvalid1, b_rdata1, cnt1);
        end
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        n_cmp++;
        if (b_rvalid2 !== 1'b0 || b_rvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_dropped: got bv2=%0b bv1=%0b, want 0", b_rvalid2, b_rvalid1);
        end
        drive_b(1, 0, 9, 4'h0, '0);
        cycle();
        idle();
        cycle();
        n_cmp++;
        if (b_rvalid2 !== 1'b1 || b_rdata2 !== w9 || b_rdata1 !== w9) begin
            n_fail++;
            $display("FAIL mid_reset_kept: got v=%0b lat2=%h lat1=%h, want v=1 d=%h", b_rvalid2, b_rdata2, b_rdata1, w9);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_reset_read();
        test_byte_strobe();
        test_write_collision();
        test_merge_forward();
        test_out_of_range();
        test_random();
        test_saturation();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
